arb_req_port: RTL and testbench

Requester-side agent for one port of the 4-way round-robin arbiter. It buffers words from a local source in a small FIFO and raises `req_o` toward the arbiter while it has data. It drives one word onto the shared bus for every cycle in which the arbiter's registered grant bit for this port is high. It also flags spurious grants and, optionally, starvation. Four instances, one per arbiter bit, form the client side of the shared bus.

---
 rtl/arb_req_port.sv | 137 +++++++++++++
 tb/tb_arb_req_port.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_port.sv
// arb_req_port -- requester-side agent for one port of a 4-way round-robin
// arbiter. Buffers source words in a small circular FIFO, requests the bus
// while data is held, and drives one word per granted cycle.
//
// Optional feature: define ARB_REQ_STARVE_EN to compile in the starvation
// counter and the sticky `starve` flag; otherwise `starve` is tied low.
module arb_req_port #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     req_o,
  input  logic                     grant_i,
  output logic                     bus_valid,
  output logic [WIDTH-1:0]         bus_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     spur_grant,
  output logic                     starve
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  // Parameter sanity checks, resolved at elaboration.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("arb_req_port: DEPTH must be a power of two >= 2");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_chk
    $error("arb_req_port: STARVE_LIMIT must be in 1..255");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Handshake decode: push refused when full regardless of a same-cycle pop.
  always_comb begin
    full      = (level == LVL_FULL);
    empty     = (level == '0);
    in_ready  = !full;
    push      = in_valid && !full;
    pop       = grant_i && !empty;
    bus_valid = pop;
    bus_data  = mem[rptr];
    // Drop the request in the cycle the last word leaves so the arbiter,
    // sampling on the same edge, never grants an empty FIFO.
    req_o     = (level > LVL_ONE) || ((level == LVL_ONE) && !grant_i);
  end

  // Storage write; contents are not reset, stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= in_data;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Sticky flag: grant observed while nothing was buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      spur_grant <= 1'b0;
    end else if (grant_i && empty) begin
      spur_grant <= 1'b1;
    end
  end

`ifdef ARB_REQ_STARVE_EN
  localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;
  logic [7:0] starve_cnt_nxt;

  // Saturating count of consecutive requested-but-ungranted cycles.
  always_comb begin
    starve_cnt_nxt = '0;
    if (req_o && !grant_i) begin
      if (starve_cnt != '1) begin
        starve_cnt_nxt = starve_cnt + 8'd1;
      end else begin
        starve_cnt_nxt = starve_cnt;
      end
    end
  end

  // Counter register and sticky starvation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      starve     <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      if (starve_cnt_nxt == STARVE_LIM8) begin
        starve <= 1'b1;
      end
    end
  end
`else
  // Feature compiled out: flag held low.
  always_comb begin
    starve = 1'b0;
  end
`endif

endmodule

// File: tb/tb_arb_req_port.sv
// Bench for arb_req_port: a queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_arb_req_port;

  localparam int WIDTH        = 8;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 15;
  localparam int LW           = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             req_o;
  logic             grant_i;
  logic             bus_valid;
  logic [WIDTH-1:0] bus_data;
  logic [LW-1:0]    level;
  logic             spur_grant;
  logic             starve;

  int n_cmp;
  int n_fail;

  arb_req_port #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .req_o     (req_o),
    .grant_i   (grant_i),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .level     (level),
    .spur_grant(spur_grant),
    .starve    (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue of words.
  logic [WIDTH-1:0] q[$];
  bit m_spur;
  bit m_starve;
  bit model_ok;
  int m_n;
  bit m_req;
`ifdef ARB_REQ_STARVE_EN
  int m_cnt;
`endif

  initial begin
    model_ok = 0;
    m_spur   = 0;
    m_starve = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_spur   = 0;
      m_starve = 0;
`ifdef ARB_REQ_STARVE_EN
      m_cnt    = 0;
`endif
      model_ok = 1;
    end else if (model_ok) begin
      m_n   = q.size();
      m_req = (m_n > 1) || (m_n == 1 && !grant_i);
      if (grant_i && m_n == 0) m_spur = 1;
`ifdef ARB_REQ_STARVE_EN
      if (m_req && !grant_i) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt == STARVE_LIMIT) m_starve = 1;
      end else begin
        m_cnt = 0;
      end
`endif
      if (grant_i && m_n != 0) void'(q.pop_front());
      if (in_valid && m_n < DEPTH) q.push_back(in_data);
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      check("m_in_ready", in_ready, q.size() < DEPTH);
      check("m_req", req_o, (q.size() > 1) || (q.size() == 1 && !grant_i));
      check("m_bus_valid", bus_valid, grant_i && q.size() != 0);
      if (grant_i && q.size() != 0) check("m_bus_data", bus_data, q[0]);
      check("m_level", level, q.size());
      check("m_spur", spur_grant, m_spur);
      check("m_starve", starve, m_starve);
    end
  end

  // One cycle with the given inputs; returns mid-cycle for directed checks.
  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic g);
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = v;
    in_data  = d;
    grant_i  = g;
    @(negedge clk);
  endtask

  logic [WIDTH-1:0] w;
  bit exp_starve;

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    grant_i  = 1'b0;
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    // Reset mid-transfer: three words buffered, grant asserted.
    step(0, 1, 8'hC1, 0);
    step(0, 1, 8'hC2, 0);
    step(0, 1, 8'hC3, 0);
    step(1, 0, 8'h00, 1);
    check("pre_rst_level", level, 3);
    step(0, 0, 8'h00, 0);
    check("rst_level", level, 0);
    check("rst_req", req_o, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_spur", spur_grant, 0);
    check("rst_starve", starve, 0);

    // Single word latency.
    step(0, 1, 8'hA5, 0);
    step(0, 0, 8'h00, 0);
    check("lat_req_c1", req_o, 1);
    check("lat_level_c1", level, 1);
    step(0, 0, 8'h00, 1);
    check("lat_bus_valid_c2", bus_valid, 1);
    check("lat_bus_data_c2", bus_data, 8'hA5);
    check("lat_req_c2", req_o, 0);
    step(0, 0, 8'h00, 0);
    check("lat_level_c3", level, 0);
    check("lat_req_c3", req_o, 0);

    // Fill to full with grant blocked, then drain in order.
    for (int i = 1; i <= 4; i++) step(0, 1, WIDTH'(i), 0);
    step(0, 1, 8'h05, 0);
    check("full_level", level, 4);
    check("full_in_ready", in_ready, 0);
    step(0, 0, 8'h00, 1);
    check("full_level_after_refuse", level, 4);
    check("drain_data_1", bus_data, 8'h01);
    for (int i = 2; i <= 4; i++) begin
      step(0, 0, 8'h00, 1);
      w = WIDTH'(i);
      check("drain_valid", bus_valid, 1);
      check("drain_data", bus_data, w);
    end
    check("drain_last_req", req_o, 0);
    step(0, 0, 8'h00, 0);
    check("drain_level", level, 0);

    // Streaming at level 2 across pointer wrap.
    step(0, 1, 8'h10, 0);
    step(0, 1, 8'h11, 0);
    for (int i = 0; i < 8; i++) begin
      w = 8'h12 + WIDTH'(i);
      step(0, 1, w, 1);
      w = 8'h10 + WIDTH'(i);
      check("stream_level", level, 2);
      check("stream_data", bus_data, w);
    end
    step(0, 0, 8'h00, 1);
    check("stream_tail_a", bus_data, 8'h18);
    step(0, 0, 8'h00, 1);
    check("stream_tail_b", bus_data, 8'h19);
    check("stream_tail_req", req_o, 0);
    step(0, 0, 8'h00, 0);
    check("stream_empty", level, 0);

    // Spurious grant on an empty FIFO.
    step(0, 0, 8'h00, 1);
    check("spur_bus_valid", bus_valid, 0);
    check("spur_not_yet", spur_grant, 0);
    step(0, 0, 8'h00, 0);
    check("spur_set", spur_grant, 1);
    step(0, 0, 8'h00, 0);
    check("spur_sticky", spur_grant, 1);

    // Starvation: request held with no grant.
`ifdef ARB_REQ_STARVE_EN
    exp_starve = 1;
`else
    exp_starve = 0;
`endif
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h55, 0);
    for (int k = 1; k <= 15; k++) begin
      step(0, 0, 8'h00, 0);
      check("starve_early", starve, 0);
    end
    step(0, 0, 8'h00, 0);
    check("starve_limit", starve, exp_starve);

    // Same, interrupted by a one-cycle grant at cycle 10.
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h66, 0);
    for (int k = 1; k <= 22; k++) begin
      step(0, k == 1, 8'h77, k == 10);
      check("starve_interrupted", starve, 0);
    end
    check("starve_interrupted_req", req_o, 1);

    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
